// File: rtl/shadow_sb_pkg.sv
// Shared types and helpers for the shadow-memory scoreboard.
// The compare record is sized for the widest supported configuration
// (ADDR_W <= 64, DATA_W <= 128, NUM_PORTS <= 16); users zero-extend into it.
package shadow_sb_pkg;

   localparam int SB_MAX_ADDR_W = 64;
   localparam int SB_MAX_DATA_W = 128;
   localparam int SB_MAX_NB     = SB_MAX_DATA_W / 8;
   localparam int SB_MAX_PORT_W = 4;

   // One read captured at E0, compared at E1
   typedef struct packed {
      logic                     vld;
      logic [SB_MAX_PORT_W-1:0] port;
      logic [SB_MAX_ADDR_W-1:0] addr;
      logic [SB_MAX_DATA_W-1:0] exp;
      logic [SB_MAX_DATA_W-1:0] got;
      logic [SB_MAX_NB-1:0]     mask;
   } cmp_rec_t;

   // Number of byte lanes in a data word
   function automatic int sbNumBytes(input int dataW);
      return dataW / 8;
   endfunction

   // Width of a port index, never less than one bit
   function automatic int sbPortWidth(input int numPorts);
      return (numPorts > 1) ? $clog2(numPorts) : 1;
   endfunction

   // Add inc to cnt, clamping the result at maxVal
   function automatic logic [31:0] satAdd(input logic [31:0] cnt,
                                          input logic [31:0] inc,
                                          input logic [31:0] maxVal);
      logic [32:0] sum;
      sum = {1'b0, cnt} + {1'b0, inc};
      return (sum > {1'b0, maxVal}) ? maxVal : sum[31:0];
   endfunction

endpackage

// File: rtl/shadow_sb_array.sv
// Byte-lane shadow RAM with per-byte valid bits.
// Multi-source writes merge per byte (init lowest priority, then ports in
// ascending index); lookups return the contents before this edge's writes.
module shadow_sb_array
   import shadow_sb_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int DATA_W     = 32,
   parameter int DEPTH_LOG2 = 10
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             initWe_i,
   input  logic [DEPTH_LOG2-1:0]            initIdx_i,
   input  logic [DATA_W-1:0]                initData_i,
   input  logic [NUM_PORTS-1:0]             wrEn_i,
   input  logic [NUM_PORTS*DEPTH_LOG2-1:0]  idx_i,
   input  logic [NUM_PORTS*DATA_W-1:0]      wrData_i,
   input  logic [NUM_PORTS*(DATA_W/8)-1:0]  wrMbe_i,
   output logic [NUM_PORTS*DATA_W-1:0]      rdData_o,
   output logic [NUM_PORTS*(DATA_W/8)-1:0]  rdMask_o
);

   localparam int NB    = sbNumBytes(DATA_W);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [DATA_W-1:0] shadowMem_q [DEPTH];
   logic [NB-1:0]     byteVld_q   [DEPTH];

   // Valid bits: cleared by reset, set by any write that touches a byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < DEPTH; w++) byteVld_q[w] <= '0;
      end else begin
         if (initWe_i) byteVld_q[initIdx_i] <= '1;
         for (int p = 0; p < NUM_PORTS; p++)
            for (int b = 0; b < NB; b++)
               if (wrEn_i[p] && wrMbe_i[p*NB+b])
                  byteVld_q[idx_i[p*DEPTH_LOG2 +: DEPTH_LOG2]][b] <= 1'b1;
      end
   end

   // Data bytes: later assignments win, so init goes first and port order is ascending
   always_ff @(posedge clk) begin
      if (initWe_i) shadowMem_q[initIdx_i] <= initData_i;
      for (int p = 0; p < NUM_PORTS; p++)
         for (int b = 0; b < NB; b++)
            if (wrEn_i[p] && wrMbe_i[p*NB+b])
               shadowMem_q[idx_i[p*DEPTH_LOG2 +: DEPTH_LOG2]][b*8 +: 8]
                  <= wrData_i[p*DATA_W + b*8 +: 8];
   end

   // Combinational lookup of the pre-edge image for every port
   always_comb begin
      rdData_o = '0;
      rdMask_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         rdData_o[p*DATA_W +: DATA_W] = shadowMem_q[idx_i[p*DEPTH_LOG2 +: DEPTH_LOG2]];
         rdMask_o[p*NB +: NB]         = byteVld_q[idx_i[p*DEPTH_LOG2 +: DEPTH_LOG2]];
      end
   end

endmodule

// File: rtl/shadow_mem_scoreboard.sv
// Shadow-memory scoreboard: mirrors completed writes into a byte-valid image
// and checks completed reads against it one cycle later.
// Optional protocol checking is enabled with SHADOW_SB_PROTOCOL_CHECK_EN.
module shadow_mem_scoreboard
   import shadow_sb_pkg::*;
#(
   parameter int               NUM_PORTS  = 2,
   parameter int               ADDR_W     = 32,
   parameter int               DATA_W     = 32,
   parameter int               DEPTH_LOG2 = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int               CNT_W      = 16,
   localparam int              NB         = DATA_W / 8,
   localparam int              PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        mon_read,
   input  logic [NUM_PORTS-1:0]        mon_write,
   input  logic [NUM_PORTS-1:0]        mon_resp,
   input  logic [NUM_PORTS*ADDR_W-1:0] mon_addr,
   input  logic [NUM_PORTS*DATA_W-1:0] mon_wdata,
   input  logic [NUM_PORTS*NB-1:0]     mon_mbe,
   input  logic [NUM_PORTS*DATA_W-1:0] mon_rdata,
   input  logic                        init_we,
   input  logic [DEPTH_LOG2-1:0]       init_idx,
   input  logic [DATA_W-1:0]           init_data,
   input  logic                        clr_err,
   output logic [NUM_PORTS-1:0]        err_pulse,
   output logic [CNT_W-1:0]            err_count,
   output logic [CNT_W-1:0]            chk_count,
   output logic                        first_err_vld,
   output logic [PORT_W-1:0]           first_err_port,
   output logic [ADDR_W-1:0]           first_err_addr,
   output logic [DATA_W-1:0]           first_err_exp,
   output logic [DATA_W-1:0]           first_err_got
`ifdef SHADOW_SB_PROTOCOL_CHECK_EN
   ,output logic [CNT_W-1:0]           proto_err_count
`endif
);

   localparam int          TAG_W   = ADDR_W - DEPTH_LOG2 - 2;
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [NUM_PORTS-1:0]            rdEv, wrEv;
   logic [NUM_PORTS*DEPTH_LOG2-1:0] wordIdx;
   logic [NUM_PORTS*DATA_W-1:0]     lookData;
   logic [NUM_PORTS*NB-1:0]         lookMask;
   cmp_rec_t                        cmp_d [NUM_PORTS];
   cmp_rec_t                        cmp_q [NUM_PORTS];
   cmp_rec_t                        firstRec;
   logic [NUM_PORTS-1:0]            errVec, errPulse_q;
   logic [31:0]                     nErr, nChk;
   logic [CNT_W-1:0]                errCount_q, errCount_d, chkCount_q, chkCount_d;
   logic                            firstVld_q;
   logic [PORT_W-1:0]               firstPort_q;
   logic [ADDR_W-1:0]               firstAddr_q;
   logic [DATA_W-1:0]               firstExp_q, firstGot_q;

   // Qualify events per port; a simultaneous read+write counts only as a read
   always_comb begin
      rdEv    = '0;
      wrEv    = '0;
      wordIdx = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         wordIdx[p*DEPTH_LOG2 +: DEPTH_LOG2] = mon_addr[p*ADDR_W + 2 +: DEPTH_LOG2];
         if (mon_addr[p*ADDR_W + DEPTH_LOG2 + 2 +: TAG_W] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2+2]) begin
            rdEv[p] = mon_resp[p] & mon_read[p];
            wrEv[p] = mon_resp[p] & mon_write[p] & ~mon_read[p];
         end
      end
   end

   shadow_sb_array #(
      .NUM_PORTS  (NUM_PORTS),
      .DATA_W     (DATA_W),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) uArray (
      .clk        (clk),
      .rst_n      (rst_n),
      .initWe_i   (init_we),
      .initIdx_i  (init_idx),
      .initData_i (init_data),
      .wrEn_i     (wrEv),
      .idx_i      (wordIdx),
      .wrData_i   (mon_wdata),
      .wrMbe_i    (mon_mbe),
      .rdData_o   (lookData),
      .rdMask_o   (lookMask)
   );

   // Build the E0 compare records from the pre-write lookup
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         cmp_d[p]      = '0;
         cmp_d[p].vld  = rdEv[p];
         cmp_d[p].port = SB_MAX_PORT_W'(p);
         cmp_d[p].addr = SB_MAX_ADDR_W'(mon_addr[p*ADDR_W +: ADDR_W]);
         cmp_d[p].exp  = SB_MAX_DATA_W'(lookData[p*DATA_W +: DATA_W]);
         cmp_d[p].got  = SB_MAX_DATA_W'(mon_rdata[p*DATA_W +: DATA_W]);
         cmp_d[p].mask = SB_MAX_NB'(lookMask[p*NB +: NB]);
      end
   end

   // Pipeline register between lookup and compare; reset drops in-flight reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) cmp_q[p] <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) cmp_q[p] <= cmp_d[p];
      end
   end

   // E1 compare over valid bytes only, plus counter next-state and first-error pick
   always_comb begin
      logic [SB_MAX_DATA_W-1:0] bitMask;
      errVec   = '0;
      nErr     = '0;
      nChk     = '0;
      firstRec = cmp_q[0];
      for (int p = 0; p < NUM_PORTS; p++) begin
         bitMask = '0;
         for (int b = 0; b < SB_MAX_NB; b++) bitMask[b*8 +: 8] = {8{cmp_q[p].mask[b]}};
         if (cmp_q[p].vld && (|cmp_q[p].mask)) begin
            nChk = nChk + 32'd1;
            if (((cmp_q[p].exp ^ cmp_q[p].got) & bitMask) != '0) begin
               errVec[p] = 1'b1;
               nErr      = nErr + 32'd1;
            end
         end
      end
      for (int p = NUM_PORTS - 1; p >= 0; p--)
         if (errVec[p]) firstRec = cmp_q[p];
      errCount_d = CNT_W'(satAdd(32'(errCount_q), nErr, CNT_MAX));
      chkCount_d = CNT_W'(satAdd(32'(chkCount_q), nChk, CNT_MAX));
   end

   // Result registers: clr_err wins over a same-edge mismatch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         errPulse_q  <= '0;
         errCount_q  <= '0;
         chkCount_q  <= '0;
         firstVld_q  <= 1'b0;
         firstPort_q <= '0;
         firstAddr_q <= '0;
         firstExp_q  <= '0;
         firstGot_q  <= '0;
      end else if (clr_err) begin
         errPulse_q  <= '0;
         errCount_q  <= '0;
         chkCount_q  <= '0;
         firstVld_q  <= 1'b0;
         firstPort_q <= '0;
         firstAddr_q <= '0;
         firstExp_q  <= '0;
         firstGot_q  <= '0;
      end else begin
         errPulse_q <= errVec;
         errCount_q <= errCount_d;
         chkCount_q <= chkCount_d;
         if (!firstVld_q && (|errVec)) begin
            firstVld_q  <= 1'b1;
            firstPort_q <= firstRec.port[PORT_W-1:0];
            firstAddr_q <= firstRec.addr[ADDR_W-1:0];
            firstExp_q  <= firstRec.exp[DATA_W-1:0];
            firstGot_q  <= firstRec.got[DATA_W-1:0];
         end
      end
   end

   assign err_pulse      = errPulse_q;
   assign err_count      = errCount_q;
   assign chk_count      = chkCount_q;
   assign first_err_vld  = firstVld_q;
   assign first_err_port = firstPort_q;
   assign first_err_addr = firstAddr_q;
   assign first_err_exp  = firstExp_q;
   assign first_err_got  = firstGot_q;

`ifdef SHADOW_SB_PROTOCOL_CHECK_EN
   logic [NUM_PORTS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]     protoCount_q, protoCount_d;

   // Flag stray responses, read+write collisions and requests withdrawn before response
   always_comb begin
      logic [31:0] nProto;
      nProto    = '0;
      pending_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         pending_d[p] = (mon_read[p] | mon_write[p]) & ~mon_resp[p];
         if ((mon_resp[p] && !(mon_read[p] || mon_write[p])) ||
             (mon_read[p] && mon_write[p]) ||
             (pending_q[p] && !(mon_read[p] || mon_write[p])))
            nProto = nProto + 32'd1;
      end
      protoCount_d = CNT_W'(satAdd(32'(protoCount_q), nProto, CNT_MAX));
   end

   // Outstanding-request tracker and protocol error counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q    <= '0;
         protoCount_q <= '0;
      end else begin
         pending_q    <= pending_d;
         protoCount_q <= clr_err ? '0 : protoCount_d;
      end
   end

   assign proto_err_count = protoCount_q;
`endif

endmodule

// File: tb/tb_shadow_mem_scoreboard.sv
// Directed testbench for shadow_mem_scoreboard (2 ports, 32-bit, CNT_W=4).
module tb_shadow_mem_scoreboard;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DL = 10;
   localparam int CW = 4;
   localparam int NB = DW / 8;

   logic              clk = 1'b0;
   logic              rstN;
   logic [NP-1:0]     monRead, monWrite, monResp;
   logic [NP*AW-1:0]  monAddr;
   logic [NP*DW-1:0]  monWdata, monRdata;
   logic [NP*NB-1:0]  monMbe;
   logic              initWe, clrErr;
   logic [DL-1:0]     initIdx;
   logic [DW-1:0]     initData;
   logic [NP-1:0]     errPulse;
   logic [CW-1:0]     errCount, chkCount;
   logic              firstErrVld;
   logic [0:0]        firstErrPort;
   logic [AW-1:0]     firstErrAddr;
   logic [DW-1:0]     firstErrExp, firstErrGot;
`ifdef SHADOW_SB_PROTOCOL_CHECK_EN
   logic [CW-1:0]     protoErrCount;
`endif

   int checkCount = 0;
   int errorCount = 0;

   shadow_mem_scoreboard #(
      .NUM_PORTS  (NP),
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .DEPTH_LOG2 (DL),
      .BASE_ADDR  (32'h0000_0000),
      .CNT_W      (CW)
   ) dut (
      .clk            (clk),
      .rst_n          (rstN),
      .mon_read       (monRead),
      .mon_write      (monWrite),
      .mon_resp       (monResp),
      .mon_addr       (monAddr),
      .mon_wdata      (monWdata),
      .mon_mbe        (monMbe),
      .mon_rdata      (monRdata),
      .init_we        (initWe),
      .init_idx       (initIdx),
      .init_data      (initData),
      .clr_err        (clrErr),
      .err_pulse      (errPulse),
      .err_count      (errCount),
      .chk_count      (chkCount),
      .first_err_vld  (firstErrVld),
      .first_err_port (firstErrPort),
      .first_err_addr (firstErrAddr),
      .first_err_exp  (firstErrExp),
      .first_err_got  (firstErrGot)
`ifdef SHADOW_SB_PROTOCOL_CHECK_EN
      ,.proto_err_count (protoErrCount)
`endif
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   // Count one comparison and report it if it does not hold
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Load one port's request fields for the next applyStimulus
   task automatic setPort(input int p, input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mbe, input logic [31:0] rdata);
      monRead[p]             = rd;
      monWrite[p]            = wr;
      monAddr[p*AW +: AW]    = addr;
      monWdata[p*DW +: DW]   = wdata;
      monMbe[p*NB +: NB]     = mbe;
      monRdata[p*DW +: DW]   = rdata;
   endtask

   // Complete the staged requests (plus any init/clr strobe) at the next posedge
   task automatic applyStimulus();
      monResp = monRead | monWrite;
      @(negedge clk);
      monRead  = '0;
      monWrite = '0;
      monResp  = '0;
      initWe   = 1'b0;
      clrErr   = 1'b0;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic checkCounts(input string tag, input int expErr, input int expChk, input logic [1:0] expPulse);
      checkOutput({tag, " err_count"}, 64'(errCount), 64'(expErr));
      checkOutput({tag, " chk_count"}, 64'(chkCount), 64'(expChk));
      checkOutput({tag, " err_pulse"}, 64'(errPulse), 64'(expPulse));
   endtask

   task automatic checkCapture(input string tag, input logic vld, input logic port,
                               input logic [31:0] addr, input logic [31:0] exp, input logic [31:0] got);
      checkOutput({tag, " first_err_vld"},  64'(firstErrVld),  64'(vld));
      checkOutput({tag, " first_err_port"}, 64'(firstErrPort), 64'(port));
      checkOutput({tag, " first_err_addr"}, 64'(firstErrAddr), 64'(addr));
      checkOutput({tag, " first_err_exp"},  64'(firstErrExp),  64'(exp));
      checkOutput({tag, " first_err_got"},  64'(firstErrGot),  64'(got));
   endtask

   initial begin
      rstN     = 1'b0;
      monRead  = '0;
      monWrite = '0;
      monResp  = '0;
      monAddr  = '0;
      monWdata = '0;
      monMbe   = '0;
      monRdata = '0;
      initWe   = 1'b0;
      initIdx  = '0;
      initData = '0;
      clrErr   = 1'b0;

      nextCycle();
      nextCycle();
      checkCounts("reset", 0, 0, 2'b00);
      checkCapture("reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      rstN = 1'b1;
      nextCycle();

      // Preload and matching read
      initWe = 1'b1; initIdx = 10'd3; initData = 32'hDEADBEEF;
      applyStimulus();
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'hDEADBEEF);
      applyStimulus();
      nextCycle();
      checkCounts("preload", 0, 1, 2'b00);

      // Partial write, read with garbage in invalid bytes
      setPort(1, 0, 1, 32'h0000_0010, 32'h0000_1234, 4'b0011, 32'h0);
      applyStimulus();
      setPort(0, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'hFFFF1234);
      applyStimulus();
      nextCycle();
      checkCounts("partial", 0, 2, 2'b00);

      // First mismatch
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'hDEADBEEE);
      applyStimulus();
      nextCycle();
      checkCounts("mismatch1", 1, 3, 2'b01);
      checkCapture("mismatch1", 1'b1, 1'b0, 32'h0000_000C, 32'hDEADBEEF, 32'hDEADBEEE);
      nextCycle();
      checkOutput("mismatch1 pulse drop", 64'(errPulse), 64'd0);

      // Second mismatch keeps the capture
      setPort(1, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h0);
      applyStimulus();
      nextCycle();
      checkCounts("mismatch2", 2, 4, 2'b10);
      checkCapture("mismatch2", 1'b1, 1'b0, 32'h0000_000C, 32'hDEADBEEF, 32'hDEADBEEE);

      // Saturation: 20 more mismatches
      for (int i = 0; i < 10; i++) begin
         setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h0);
         setPort(1, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h1);
         applyStimulus();
      end
      nextCycle();
      checkCounts("saturate", 15, 15, 2'b11);

      // Clear
      clrErr = 1'b1;
      applyStimulus();
      checkCounts("clear", 0, 0, 2'b00);
      checkCapture("clear", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

      // Dual mismatch in one cycle: lowest port captured
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h0);
      setPort(1, 1, 0, 32'h0000_0010, 32'h0, 4'h0, 32'h0);
      applyStimulus();
      nextCycle();
      checkCounts("dual mismatch", 2, 2, 2'b11);
      checkCapture("dual mismatch", 1'b1, 1'b0, 32'h0000_000C, 32'hDEADBEEF, 32'h0);

      // Same-edge read and write: read sees old data, next read sees new
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'hDEADBEEF);
      setPort(1, 0, 1, 32'h0000_000C, 32'hCAFEF00D, 4'hF, 32'h0);
      applyStimulus();
      nextCycle();
      checkCounts("rbw old", 2, 3, 2'b00);
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'hCAFEF00D);
      applyStimulus();
      nextCycle();
      checkCounts("rbw new", 2, 4, 2'b00);

      // Dual write to the same bytes: port 1 persists
      setPort(0, 0, 1, 32'h0000_0014, 32'h11111111, 4'hF, 32'h0);
      setPort(1, 0, 1, 32'h0000_0014, 32'h22222222, 4'hF, 32'h0);
      applyStimulus();
      setPort(0, 1, 0, 32'h0000_0014, 32'h0, 4'h0, 32'h22222222);
      applyStimulus();
      nextCycle();
      checkCounts("dual write p1", 2, 5, 2'b00);
      setPort(0, 1, 0, 32'h0000_0014, 32'h0, 4'h0, 32'h11111111);
      applyStimulus();
      nextCycle();
      checkCounts("dual write p0", 3, 6, 2'b01);

      // Port write beats init on the same edge
      initWe = 1'b1; initIdx = 10'd6; initData = 32'hAAAAAAAA;
      setPort(0, 0, 1, 32'h0000_0018, 32'h000000BB, 4'b0001, 32'h0);
      applyStimulus();
      setPort(0, 1, 0, 32'h0000_0018, 32'h0, 4'h0, 32'hAAAAAABB);
      applyStimulus();
      nextCycle();
      checkCounts("init vs port", 3, 7, 2'b00);

      // Out-of-window read is ignored
      setPort(0, 1, 0, 32'h0000_1018, 32'h0, 4'h0, 32'h0);
      applyStimulus();
      nextCycle();
      checkCounts("out of window", 3, 7, 2'b00);

      // Read+write together is a read only
      setPort(1, 1, 1, 32'h0000_0018, 32'h0, 4'hF, 32'hAAAAAABB);
      applyStimulus();
      setPort(0, 1, 0, 32'h0000_0018, 32'h0, 4'h0, 32'hAAAAAABB);
      applyStimulus();
      nextCycle();
      checkCounts("rd+wr", 3, 9, 2'b00);

      // Never-written word is not a check
      setPort(0, 1, 0, 32'h0000_0040, 32'h0, 4'h0, 32'h12345678);
      applyStimulus();
      nextCycle();
      checkCounts("unwritten", 3, 9, 2'b00);
      checkCapture("late", 1'b1, 1'b0, 32'h0000_000C, 32'hDEADBEEF, 32'h0);

      // Reset between E0 and E1 of a mismatching read
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h0);
      applyStimulus();
      rstN = 1'b0;
      #1;
      checkCounts("midreset async", 0, 0, 2'b00);
      nextCycle();
      checkCounts("midreset held", 0, 0, 2'b00);
      checkCapture("midreset", 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
      rstN = 1'b1;
      nextCycle();
      checkCounts("post reset", 0, 0, 2'b00);
      setPort(0, 1, 0, 32'h0000_000C, 32'h0, 4'h0, 32'h0);
      applyStimulus();
      nextCycle();
      checkCounts("post reset read", 0, 0, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/shadow_mem_scoreboard.md
Name: shadow_mem_scoreboard

Overview:
- Synthesizable, parametrised shadow-memory scoreboard for the multi-port CPU memory interface.
- Keeps a byte-valid shadow image of a fixed address window and applies every completed write from any of NUM_PORTS ports.
- Checks every completed read against the image and reports mismatches through saturating counters and a sticky first-error capture.
- Sits beside the DUT on the memory-side buses; usable in simulation and on FPGA bring-up.

Parameters:
- NUM_PORTS, 2, number of monitored request/response ports (port 0 = instruction, port 1 = data).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; a multiple of 8. NB = DATA_W/8 byte lanes.
- DEPTH_LOG2, 10, log2 of shadow words; the window covers 2^DEPTH_LOG2 words.
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to the window size.
- CNT_W, 16, width of the error and check counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mon_read  in  NUM_PORTS  per-port read request.
- mon_write  in  NUM_PORTS  per-port write request.
- mon_resp  in  NUM_PORTS  per-port response; completes the request.
- mon_addr  in  NUM_PORTS*ADDR_W  byte addresses; port p occupies slice [p*ADDR_W +: ADDR_W].
- mon_wdata  in  NUM_PORTS*DATA_W  write data.
- mon_mbe  in  NUM_PORTS*NB  write byte enables.
- mon_rdata  in  NUM_PORTS*DATA_W  read data returned by the DUT.
- init_we  in  1  preload strobe.
- init_idx  in  DEPTH_LOG2  preload word index.
- init_data  in  DATA_W  preload word; all bytes marked valid.
- clr_err  in  1  clears counters and the first-error capture.
- err_pulse  out  NUM_PORTS  per-port mismatch flag, one cycle.
- err_count  out  CNT_W  total mismatches, saturating.
- chk_count  out  CNT_W  total reads compared, saturating.
- first_err_vld  out  1  sticky; first-error capture is valid.
- first_err_port  out  $clog2(NUM_PORTS) (minimum 1 bit)  port of the first mismatch.
- first_err_addr  out  ADDR_W  address of the first mismatch.
- first_err_exp  out  DATA_W  expected data of the first mismatch.
- first_err_got  out  DATA_W  detected data of the first mismatch.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low on rst_n.
  - All outputs are 0 in reset.
  - All byte-valid bits are cleared. Shadow data contents are don't-care.
- Event qualification:
  - A read event is mon_resp[p] && mon_read[p] && address in window.
  - A write event is mon_resp[p] && mon_write[p] && address in window.
  - An address is in the window when addr[ADDR_W-1:DEPTH_LOG2+2] == BASE_ADDR[ADDR_W-1:DEPTH_LOG2+2].
  - Word index = addr[DEPTH_LOG2+1:2]. addr[1:0] is ignored.
  - Out-of-window events are ignored and are not counted.
- Writes:
  - A write event at edge E0 updates the enabled bytes and sets their valid bits at E0.
  - Same edge, same word, multiple sources: per byte, the highest port index wins over lower ports, and any port wins over init.
- Reads:
  - At E0 the expected word and its valid mask are looked up from the image as it stands before E0's writes (read-before-write), then registered together with got, addr and port.
  - At E1 only valid bytes are compared. A read whose mask is all-invalid is not a check.
- Outputs:
  - err_pulse[p] is high for exactly the cycle after E1.
  - err_count and chk_count add the number of mismatching ports and checked ports respectively (0..NUM_PORTS) at E1. Both saturate at all-ones.
- First-error capture:
  - Taken on the first mismatch while first_err_vld==0.
  - If several ports mismatch in the same cycle, the lowest port index is captured.
  - Later mismatches do not overwrite the capture.
- clr_err:
  - At an edge it clears both counters, first_err_vld and the capture fields.
  - A mismatch at the same edge is dropped.
  - It does not affect the shadow image or the pipeline register.
- Other rules:
  - mon_read[p] && mon_write[p] asserted together is treated as a read only.
  - Reset asserted mid-pipeline discards the in-flight compare; no err_pulse follows reset release.

Optional Feature:
- SHADOW_SB_PROTOCOL_CHECK_EN defined:
  - Adds output proto_err_count (CNT_W, saturating, reset 0, cleared by clr_err).
  - It increments once per port per cycle for:
    - mon_resp[p] without mon_read[p] or mon_write[p];
    - mon_read[p] && mon_write[p] together;
    - a request on any port dropping before its mon_resp.
  - A one-bit-per-port pending register tracks outstanding requests.
- Undefined: no port, no pending register, no protocol checking.

Decomposition:
- Package shadow_sb_pkg holds the per-port compare record typedef (vld, port, addr, exp, got, mask), a saturating-add function, and the NB/index-width localparam helpers.
- One sub-module, shadow_sb_array: the byte-lane shadow RAM with valid bits, multi-source write merge and read-before-write lookup.

Test Plan:
- Preload: init word 3 = 32'hDEADBEEF, then a port-0 read at addr 0xC returning 32'hDEADBEEF -> chk_count=1, err_count=0, err_pulse stays 0.
- Partial write: port-1 write to 0x10 with mbe=4'b0011 and wdata 32'h0000_1234 (word previously unwritten), then a read returning 32'hFFFF1234 -> checked with no error, because the upper bytes are invalid.
- Mismatch: a read of 0xC returning 32'hDEADBEEE -> err_pulse[0] the cycle after E1, err_count=1, capture = port 0, addr 0xC, exp DEADBEEF, got DEADBEEE. A second mismatch leaves the capture unchanged.
- Same-cycle hazard:
  - port-0 read and port-1 write to 0xC at the same edge -> the read compares against DEADBEEF;
  - a following read sees the new data;
  - a dual write to the same bytes -> port 1's data persists.
- Saturation/clear: with CNT_W=4, force 20 mismatches -> err_count=15. Pulse clr_err -> counts 0, first_err_vld=0.
- Reset mid-op: assert rst_n low between E0 and E1 of a mismatching read -> no err_pulse, all outputs 0, and a previously valid word now reads as unchecked.
